// File: rtl/serv_wb_arbiter_if.sv
// serv_wb_arbiter_if
//  Bundles the three buses the arbiter connects:
//   - ibus : SERV instruction fetch port (adr/cyc in, rdt/ack out)
//   - dbus : SERV data port (adr/dat/sel/we/cyc in, rdt/ack out)
//   - wb   : merged Wishbone master port towards the memory/peripheral
//  Modports:
//   - master : the arbiter's view. It drives the merged Wishbone request and
//              the per-master responses.
//   - slave  : the surrounding system's view. It drives the core requests and
//              the slave response, and observes everything else.
interface serv_wb_arbiter_if;
    // Instruction bus (core side)
    logic [31:0] ibus_adr;
    logic        ibus_cyc;
    logic [31:0] ibus_rdt;
    logic        ibus_ack;

    // Data bus (core side)
    logic [31:0] dbus_adr;
    logic [31:0] dbus_dat;
    logic [3:0]  dbus_sel;
    logic        dbus_we;
    logic        dbus_cyc;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;

    // Merged Wishbone port (memory side)
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic [31:0] wb_rdt;
    logic        wb_ack;

    modport master (
        input  ibus_adr, ibus_cyc,
        output ibus_rdt, ibus_ack,
        input  dbus_adr, dbus_dat, dbus_sel, dbus_we, dbus_cyc,
        output dbus_rdt, dbus_ack,
        output wb_adr, wb_dat, wb_sel, wb_we, wb_cyc,
        input  wb_rdt, wb_ack
    );

    modport slave (
        output ibus_adr, ibus_cyc,
        input  ibus_rdt, ibus_ack,
        output dbus_adr, dbus_dat, dbus_sel, dbus_we, dbus_cyc,
        input  dbus_rdt, dbus_ack,
        input  wb_adr, wb_dat, wb_sel, wb_we, wb_cyc,
        output wb_rdt, wb_ack
    );
endinterface

// File: rtl/serv_wb_arbiter.sv
// serv_wb_arbiter
//  Merges the SERV instruction bus and data bus onto a single Wishbone master
//  port. A registered grant (IDLE / GNT_I / GNT_D) selects which core bus is
//  routed to the memory side; the grant is held until the slave acks or the
//  granted master drops its cycle. Ties are resolved round-robin, with dbus
//  winning the first tie after reset.
//  Also provides a stall watchdog (timeout) and a sticky protocol error flag
//  raised when the slave acks while no cycle is presented.
// Ports:
//  clock        : system clock, rising edge
//  reset        : synchronous active-high reset
//  bus          : serv_wb_arbiter_if.master (ibus, dbus and merged wb signals)
//  timeout      : registered, high while the stall count is >= MAX_WAIT
//  protocol_err : sticky, set by an ack seen while wb_cyc is low
// Parameters:
//  MAX_WAIT     : stall cycles (cyc high, no ack) before timeout asserts, 1..255
module serv_wb_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    serv_wb_arbiter_if.master     bus,
    output logic                  timeout,
    output logic                  protocol_err
);

    localparam logic [7:0] MAX_WAIT_W = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t      state_reg;
    logic        last_d_reg;        // 1 when dbus was the most recent grant
    logic [7:0]  count_reg;
    logic [7:0]  count_next;
    logic        timeout_reg;
    logic        protocol_err_reg;

    // Merged request and per-master acks (combinational from the grant)
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        ibus_ack;
    logic        dbus_ack;

    // ------------------------------------------------------------------
    // Request routing. The mux select is the registered grant, so a new
    // request reaches the slave one cycle after it appears. While reset is
    // high everything is forced low so an in-flight ack cannot leak through.
    // ------------------------------------------------------------------
    always_comb begin
        wb_adr   = 32'd0;
        wb_dat   = 32'd0;
        wb_sel   = 4'd0;
        wb_we    = 1'b0;
        wb_cyc   = 1'b0;
        ibus_ack = 1'b0;
        dbus_ack = 1'b0;
        if (!reset) begin
            case (state_reg)
                GNT_I: begin
                    wb_adr   = bus.ibus_adr;
                    wb_sel   = 4'hf;
                    wb_cyc   = bus.ibus_cyc;
                    // Gating on cyc drops a slave ack that lands after an abort
                    ibus_ack = bus.ibus_cyc & bus.wb_ack;
                end
                GNT_D: begin
                    wb_adr   = bus.dbus_adr;
                    wb_dat   = bus.dbus_dat;
                    wb_sel   = bus.dbus_sel;
                    wb_we    = bus.dbus_we;
                    wb_cyc   = bus.dbus_cyc;
                    dbus_ack = bus.dbus_cyc & bus.wb_ack;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Watchdog: counts cycles with an outstanding, un-acked cycle and
    // saturates at 255 so a long stall never wraps back below MAX_WAIT.
    // ------------------------------------------------------------------
    always_comb begin
        count_next = 8'd0;
        if (wb_cyc && !bus.wb_ack) begin
            count_next = (count_reg == 8'hff) ? count_reg : count_reg + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Grant FSM, watchdog and error flag state
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= IDLE;
            last_d_reg       <= 1'b0;
            count_reg        <= 8'd0;
            timeout_reg      <= 1'b0;
            protocol_err_reg <= 1'b0;
        end else begin
            count_reg   <= count_next;
            // Comparing the next count keeps timeout aligned with count_reg
            timeout_reg <= (count_next >= MAX_WAIT_W);

            if (bus.wb_ack && !wb_cyc) begin
                protocol_err_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    // On a tie the master that was not granted last wins
                    if (bus.dbus_cyc && (!bus.ibus_cyc || !last_d_reg)) begin
                        state_reg  <= GNT_D;
                        last_d_reg <= 1'b1;
                    end else if (bus.ibus_cyc) begin
                        state_reg  <= GNT_I;
                        last_d_reg <= 1'b0;
                    end
                end
                GNT_I: begin
                    // Release on completion or on abort (cyc dropped)
                    if (!bus.ibus_cyc || bus.wb_ack) begin
                        state_reg <= IDLE;
                    end
                end
                GNT_D: begin
                    if (!bus.dbus_cyc || bus.wb_ack) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output drive. Read data is broadcast; each master qualifies it with
    // its own ack.
    // ------------------------------------------------------------------
    assign bus.wb_adr   = wb_adr;
    assign bus.wb_dat   = wb_dat;
    assign bus.wb_sel   = wb_sel;
    assign bus.wb_we    = wb_we;
    assign bus.wb_cyc   = wb_cyc;
    assign bus.ibus_ack = ibus_ack;
    assign bus.dbus_ack = dbus_ack;
    assign bus.ibus_rdt = bus.wb_rdt;
    assign bus.dbus_rdt = bus.wb_rdt;

    assign timeout      = timeout_reg;
    assign protocol_err = protocol_err_reg;

endmodule
